// File: rtl/cond_code_unit.sv
// Integer condition-code register with SPARC Bicc branch evaluation.
// Branch results are registered and appear as a one-cycle br_done pulse; stall freezes everything.
module cond_code_unit #(
  parameter bit FORWARD = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] flags_in,
  input  logic       cc_we,
  input  logic       stall,
  input  logic       br_valid,
  input  logic [3:0] br_cond,
  input  logic       br_annul,
  output logic [3:0] icc,
  output logic       cin_out,
  output logic       br_done,
  output logic       br_taken,
  output logic       annul_slot
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_DONE = 1'b1
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_icc;
  logic [3:0] w_icc_nxt;
  logic [3:0] w_eval_flags;
  logic       r_taken;
  logic       r_annul;
  logic       w_taken_nxt;
  logic       w_annul_nxt;
  logic       w_cond_true;
  logic       w_z;
  logic       w_n;
  logic       w_c;
  logic       w_v;

  // A cc-modifying instruction in the same cycle as the branch is bypassed when forwarding.
  always_comb begin
    w_eval_flags = r_icc;
    if (FORWARD && cc_we) begin
      w_eval_flags = flags_in;
    end
  end

  assign w_z = w_eval_flags[3];
  assign w_n = w_eval_flags[2];
  assign w_c = w_eval_flags[1];
  assign w_v = w_eval_flags[0];

  always_comb begin
    w_cond_true = 1'b0;
    case (br_cond)
      4'b0000: w_cond_true = 1'b0;
      4'b0001: w_cond_true = w_z;
      4'b0010: w_cond_true = w_z | (w_n ^ w_v);
      4'b0011: w_cond_true = w_n ^ w_v;
      4'b0100: w_cond_true = w_c | w_z;
      4'b0101: w_cond_true = w_c;
      4'b0110: w_cond_true = w_n;
      4'b0111: w_cond_true = w_v;
      4'b1000: w_cond_true = 1'b1;
      4'b1001: w_cond_true = ~w_z;
      4'b1010: w_cond_true = ~(w_z | (w_n ^ w_v));
      4'b1011: w_cond_true = ~(w_n ^ w_v);
      4'b1100: w_cond_true = ~(w_c | w_z);
      4'b1101: w_cond_true = ~w_c;
      4'b1110: w_cond_true = ~w_n;
      4'b1111: w_cond_true = ~w_v;
      default: w_cond_true = 1'b0;
    endcase
  end

  always_comb begin
    w_icc_nxt = r_icc;
    if (cc_we && !stall) begin
      w_icc_nxt = flags_in;
    end
  end

  // Next-state and registered result; stall holds the current pulse and its payload.
  always_comb begin
    w_state_nxt = r_state;
    w_taken_nxt = r_taken;
    w_annul_nxt = r_annul;
    if (!stall) begin
      if (br_valid) begin
        w_state_nxt = S_DONE;
        w_taken_nxt = w_cond_true;
        w_annul_nxt = br_annul & (~w_cond_true | (br_cond == 4'b1000));
      end else begin
        w_state_nxt = S_IDLE;
        w_taken_nxt = 1'b0;
        w_annul_nxt = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_icc   <= '0;
      r_taken <= 1'b0;
      r_annul <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_icc   <= w_icc_nxt;
      r_taken <= w_taken_nxt;
      r_annul <= w_annul_nxt;
    end
  end

  assign icc        = r_icc;
  assign cin_out    = r_icc[1];
  assign br_done    = (r_state == S_DONE);
  assign br_taken   = r_taken;
  assign annul_slot = r_annul;

endmodule

// File: tb/tb_cond_code_unit.sv
// Scoreboard bench for cond_code_unit: one forwarding and one non-forwarding instance share stimulus.
module tb_cond_code_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] flags_in;
  logic       cc_we;
  logic       stall;
  logic       br_valid;
  logic [3:0] br_cond;
  logic       br_annul;

  logic [3:0] icc1, icc0;
  logic       cin1, cin0, done1, done0, tkn1, tkn0, ann1, ann0;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  typedef struct {
    logic [3:0] icc;
    logic       done;
    logic       taken;
    logic       annul;
  } st_t;

  typedef struct {
    st_t f1;
    st_t f0;
  } exp_t;

  exp_t q[$];
  st_t  m1;
  st_t  m0;

  always #5 clk = ~clk;

  cond_code_unit #(.FORWARD(1'b1)) u_fwd (
    .clk(clk), .reset(reset), .flags_in(flags_in), .cc_we(cc_we), .stall(stall),
    .br_valid(br_valid), .br_cond(br_cond), .br_annul(br_annul),
    .icc(icc1), .cin_out(cin1), .br_done(done1), .br_taken(tkn1), .annul_slot(ann1)
  );

  cond_code_unit #(.FORWARD(1'b0)) u_nofwd (
    .clk(clk), .reset(reset), .flags_in(flags_in), .cc_we(cc_we), .stall(stall),
    .br_valid(br_valid), .br_cond(br_cond), .br_annul(br_annul),
    .icc(icc0), .cin_out(cin0), .br_done(done0), .br_taken(tkn0), .annul_slot(ann0)
  );

  // Bicc semantics: low three bits select a base test, bit 3 negates it.
  function automatic bit cond_true(input logic [3:0] c, input logic [3:0] fl);
    bit z, n, cy, v, base;
    z = fl[3]; n = fl[2]; cy = fl[1]; v = fl[0];
    case (c[2:0])
      3'd0: base = 1'b0;
      3'd1: base = z;
      3'd2: base = z | (n ^ v);
      3'd3: base = n ^ v;
      3'd4: base = cy | z;
      3'd5: base = cy;
      3'd6: base = n;
      default: base = v;
    endcase
    return base ^ c[3];
  endfunction

  function automatic st_t step(input st_t s, input bit fwd, input logic [3:0] fl_in,
                               input logic we, input logic stl, input logic vld,
                               input logic [3:0] c, input logic an);
    st_t n;
    logic [3:0] fl;
    bit t;
    n = s;
    if (stl) return n;
    fl = (fwd && we) ? fl_in : s.icc;
    t = cond_true(c, fl);
    n.done  = vld;
    n.taken = vld && t;
    n.annul = vld && an && (!t || c == 4'd8);
    if (we) n.icc = fl_in;
    return n;
  endfunction

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  task automatic check_all(input st_t e1, input st_t e0);
    check("icc_f1", icc1, e1.icc);
    check("cin_f1", {3'b0, cin1}, {3'b0, e1.icc[1]});
    check("done_f1", {3'b0, done1}, {3'b0, e1.done});
    check("taken_f1", {3'b0, tkn1}, {3'b0, e1.taken});
    check("annul_f1", {3'b0, ann1}, {3'b0, e1.annul});
    check("icc_f0", icc0, e0.icc);
    check("cin_f0", {3'b0, cin0}, {3'b0, e0.icc[1]});
    check("done_f0", {3'b0, done0}, {3'b0, e0.done});
    check("taken_f0", {3'b0, tkn0}, {3'b0, e0.taken});
    check("annul_f0", {3'b0, ann0}, {3'b0, e0.annul});
  endtask

  // Drive one cycle at the falling edge and queue the state both units should hold after the next rise.
  task automatic cyc(input logic vld, input logic [3:0] c, input logic an,
                     input logic we, input logic [3:0] fl, input logic stl);
    exp_t e;
    @(negedge clk);
    br_valid = vld; br_cond = c; br_annul = an; cc_we = we; flags_in = fl; stall = stl;
    m1 = step(m1, 1'b1, fl, we, stl, vld, c, an);
    m0 = step(m0, 1'b0, fl, we, stl, vld, c, an);
    e.f1 = m1;
    e.f0 = m0;
    q.push_back(e);
  endtask

  // Monitor: the DUT answers every edge, so each edge consumes one queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check_all(e.f1, e.f0);
      end
    end
  end

  initial begin
    st_t zero;
    zero = '{icc: 4'd0, done: 1'b0, taken: 1'b0, annul: 1'b0};
    m1 = zero;
    m0 = zero;
    reset = 1'b1; flags_in = '0; cc_we = 1'b0; stall = 1'b0;
    br_valid = 1'b0; br_cond = '0; br_annul = 1'b0;
    #2;
    check_all(zero, zero);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // BL after N set: forwarded and stored paths both see N^V=1 on the second cycle.
    cyc(1'b0, 4'd0, 1'b0, 1'b1, 4'b0100, 1'b0);
    cyc(1'b1, 4'b0011, 1'b0, 1'b0, 4'b0000, 1'b0);
    cyc(1'b0, 4'd0, 1'b0, 1'b0, 4'b0000, 1'b0);

    // Same-cycle flag update against BE distinguishes forwarding.
    cyc(1'b0, 4'd0, 1'b0, 1'b1, 4'b1000, 1'b0);
    cyc(1'b1, 4'b0001, 1'b0, 1'b1, 4'b0000, 1'b0);
    cyc(1'b0, 4'd0, 1'b0, 1'b0, 4'b0000, 1'b0);

    // Annul cases: BA,a / BN,a / BCS,a with C set, back to back.
    cyc(1'b1, 4'b1000, 1'b1, 1'b1, 4'b0010, 1'b0);
    cyc(1'b1, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0);
    cyc(1'b1, 4'b0101, 1'b1, 1'b0, 4'b0000, 1'b0);
    cyc(1'b0, 4'd0, 1'b0, 1'b0, 4'b0000, 1'b0);

    // Stall holds icc and stretches the pulse; inputs during stall are ignored.
    cyc(1'b0, 4'd0, 1'b0, 1'b1, 4'b0010, 1'b0);
    cyc(1'b1, 4'b0101, 1'b0, 1'b0, 4'b0000, 1'b0);
    cyc(1'b1, 4'b0001, 1'b1, 1'b1, 4'b1111, 1'b1);
    cyc(1'b1, 4'b0110, 1'b0, 1'b1, 4'b0101, 1'b1);
    cyc(1'b0, 4'b0000, 1'b1, 1'b1, 4'b1000, 1'b1);
    cyc(1'b0, 4'd0, 1'b0, 1'b0, 4'b0000, 1'b0);
    cyc(1'b0, 4'd0, 1'b0, 1'b0, 4'b0000, 1'b0);

    // Reset mid-pulse clears everything without a clock edge.
    cyc(1'b0, 4'd0, 1'b0, 1'b1, 4'b1010, 1'b0);
    cyc(1'b1, 4'b0001, 1'b1, 1'b0, 4'b0000, 1'b0);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    m1 = zero;
    m0 = zero;
    check_all(zero, zero);
    reset = 1'b0;
    cyc(1'b1, 4'b1001, 1'b0, 1'b0, 4'b0000, 1'b0);
    cyc(1'b0, 4'd0, 1'b0, 1'b0, 4'b0000, 1'b0);

    // Full condition sweep, with an idle cycle after each branch.
    for (int c = 0; c < 16; c++) begin
      for (int f = 0; f < 16; f++) begin
        cyc(1'b1, 4'(c), f[0], 1'b1, 4'(f), 1'b0);
        cyc(1'b0, 4'($urandom_range(15)), 1'b1, 1'b0, 4'(f ^ 5), 1'b0);
      end
    end

    // Random traffic including stalls and back-to-back branches.
    for (int i = 0; i < 500; i++) begin
      cyc(1'($urandom_range(1)), 4'($urandom_range(15)), 1'($urandom_range(1)),
          ($urandom_range(2) == 0), 4'($urandom_range(15)), ($urandom_range(4) == 0));
    end
    cyc(1'b0, 4'd0, 1'b0, 1'b0, 4'b0000, 1'b0);

    @(posedge clk);
    #2;
    check("queue_drained", 4'(q.size()), 4'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
